// File: rtl/demux2_stream.sv
// Elastic 1-to-2 valid/ready demultiplexer with a main+skid buffer.
// The head word is routed to port A or port B by its select bit, and words leave strictly in order.
module demux2_stream #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               mSel_q, mSel_d;
   logic [WIDTH-1:0]   mData_q, mData_d;
   logic               sSel_q, sSel_d;
   logic [WIDTH-1:0]   sData_q, sData_d;
   logic [CNT_W-1:0]   cntA_q, cntA_d;
   logic [CNT_W-1:0]   cntB_q, cntB_d;

   logic occupied;
   logic inFire;
   logic aFire;
   logic bFire;
   logic outFire;

   // Every handshake output is decoded from registers only, so ready never ripples back to in_ready.
   assign occupied = (state_q != EMPTY);
   assign in_ready = (state_q != TWO);
   assign a_valid  = occupied & ~mSel_q;
   assign b_valid  = occupied &  mSel_q;
   assign a_data   = occupied ? mData_q : '0;
   assign b_data   = occupied ? mData_q : '0;
   assign cnt_a    = cntA_q;
   assign cnt_b    = cntB_q;

   assign inFire  = in_valid & in_ready;
   assign aFire   = a_valid & a_ready;
   assign bFire   = b_valid & b_ready;
   assign outFire = aFire | bFire;

   always_comb begin
      state_d = state_q;
      mSel_d  = mSel_q;
      mData_d = mData_q;
      sSel_d  = sSel_q;
      sData_d = sData_q;
      cntA_d  = aFire ? cntA_q + CNT_W'(1) : cntA_q;
      cntB_d  = bFire ? cntB_q + CNT_W'(1) : cntB_q;

      unique case (state_q)
         EMPTY: begin
            if (inFire) begin
               state_d = ONE;
               mSel_d  = in_sel;
               mData_d = in_data;
            end
         end
         ONE: begin
            if (inFire && !outFire) begin
               state_d = TWO;
               sSel_d  = in_sel;
               sData_d = in_data;
            end else if (inFire && outFire) begin
               mSel_d  = in_sel;
               mData_d = in_data;
            end else if (outFire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // The skid word moves up to the head; input stays blocked this cycle.
            if (outFire) begin
               state_d = ONE;
               mSel_d  = sSel_q;
               mData_d = sData_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         mSel_q  <= 1'b0;
         mData_q <= '0;
         sSel_q  <= 1'b0;
         sData_q <= '0;
         cntA_q  <= '0;
         cntB_q  <= '0;
      end else begin
         state_q <= state_d;
         mSel_q  <= mSel_d;
         mData_q <= mData_d;
         sSel_q  <= sSel_d;
         sData_q <= sData_d;
         cntA_q  <= cntA_d;
         cntB_q  <= cntB_d;
      end
   end

endmodule
